// File: rtl/seq_right_shifter.sv
// Sequential right shifter: one bit position per clock, logical or arithmetic.
// An operation is accepted from IDLE or DONE, shifts shamt times in SHIFT,
// then presents the result for one cycle in DONE.
module seq_right_shifter #(
  parameter int N = 32,
  parameter int S = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         arith,
  input  logic [N-1:0] x,
  input  logic [S-1:0] shamt,
  output logic [N-1:0] y,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] y_q, y_d;
  logic [S-1:0] cnt_q, cnt_d;
  logic         fill_q, fill_d;

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
    end
  end

  // Next-state and datapath update; start is only honoured in IDLE or DONE.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          y_d     = x;
          cnt_d   = shamt;
          fill_d  = arith & x[N-1];
          state_d = (shamt != '0) ? SHIFT : DONE;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        y_d   = {fill_q, y_q[N-1:1]};
        cnt_d = cnt_q - S'(1);
        if (cnt_q == S'(1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only.
  assign y    = y_q;
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

endmodule
